router_reg_p: RTL and testbench

Parametrised successor of the router 1x3 data-path register. It sits between the source port and the three output FIFOs, under control of the router FSM. It latches the packet header, steers header, payload and held bytes onto `dout`, and absorbs one byte while the target FIFO is full. It also accumulates running parity and compares it against the trailing parity byte. New in this generation: generic data/address widths, a registered destination address, and an optional payload-length check.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_parity_acc.sv | 105 ++++++++++
 rtl/router_reg_p.sv | 91 +++++++++
 tb/tb_router_reg_p.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared defaults and header-field helpers for the router data-path register.
// Field layout of a header byte: {length[DATA_W-1:ADDR_W], address[ADDR_W-1:0]}.
package router_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 2;
   localparam int LEN_W      = DATA_W_DEF - ADDR_W_DEF;

   // Helpers work on a fixed wide container so any parameterisation up to this width can use them;
   // callers zero-extend the header in and cast the result down to the field width.
   localparam int HDR_MAX_W  = 32;

   function automatic logic [HDR_MAX_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr,
                                                     input int                   addr_w);
      return hdr & ((HDR_MAX_W'(1) << addr_w) - HDR_MAX_W'(1));
   endfunction

   function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] hdr,
                                                    input int                   addr_w,
                                                    input int                   data_w);
      return (hdr & ((HDR_MAX_W'(1) << data_w) - HDR_MAX_W'(1))) >> addr_w;
   endfunction

endpackage

// File: rtl/router_parity_acc.sv
// router_parity_acc: running parity, parity-byte capture, parity error and the optional
// payload-length check. ROUTER_REG_LEN_CHECK_EN enables the payload counter and len_err;
// without it len_err is a constant 0.
module router_parity_acc
   import router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic              fifo_full,
   input  logic              low_pkt_valid,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] hdr_reg,
   output logic              parity_done,
   output logic              err,
   output logic              len_err
);

   localparam int LEN_BITS = DATA_W - ADDR_W;

   logic [DATA_W-1:0] int_par;
   logic [DATA_W-1:0] pkt_par;
   logic              pay_upd;
   logic              cap;

   // A payload byte counts once, on the load cycle it is accepted from the source.
   assign pay_upd = ld_state && pkt_valid && !full_state;

   // Parity byte arrives either directly in load, or after a full stall via load-after-full.
   assign cap = (ld_state && !fifo_full && !pkt_valid) ||
                (laf_state && low_pkt_valid && !parity_done);

   // Running XOR of header and accepted payload bytes.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         int_par <= '0;
      end else if (detect_add) begin
         int_par <= '0;
      end else if (lfd_state) begin
         int_par <= int_par ^ hdr_reg;
      end else if (pay_upd) begin
         int_par <= int_par ^ data_in;
      end
   end

   // Parity-byte capture and registered comparison, evaluated one edge after capture.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pkt_par     <= '0;
         parity_done <= 1'b0;
         err         <= 1'b0;
      end else if (detect_add) begin
         parity_done <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (cap) begin
            pkt_par     <= data_in;
            parity_done <= 1'b1;
         end
         if (parity_done) begin
            err <= (int_par != pkt_par);
         end
      end
   end

`ifdef ROUTER_REG_LEN_CHECK_EN
   logic [LEN_BITS:0] pay_cnt;
   logic [LEN_BITS:0] hdr_len_ext;

   assign hdr_len_ext = {1'b0, LEN_BITS'(hdr_len(HDR_MAX_W'(hdr_reg), ADDR_W, DATA_W))};

   // Saturating payload byte counter; one extra bit so an overlong packet cannot alias a legal length.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pay_cnt <= '0;
      end else if (detect_add) begin
         pay_cnt <= '0;
      end else if (pay_upd && (pay_cnt != {(LEN_BITS+1){1'b1}})) begin
         pay_cnt <= pay_cnt + 1'b1;
      end
   end

   // Length comparison shares the timing of the parity comparison.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         len_err <= 1'b0;
      end else if (detect_add) begin
         len_err <= 1'b0;
      end else if (parity_done) begin
         len_err <= (pay_cnt != hdr_len_ext);
      end
   end
`else
   assign len_err = 1'b0;
`endif

endmodule

// File: rtl/router_reg_p.sv
// router_reg_p: router 1x3 data-path register. Latches the header, steers header/payload/held
// bytes onto dout, tracks the falling edge of pkt_valid, and delegates parity and length
// checking to router_parity_acc. Optional feature macro: ROUTER_REG_LEN_CHECK_EN.
module router_reg_p
   import router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              rst_int_reg,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err,
   output logic              len_err,
   output logic [ADDR_W-1:0] dest_addr,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] hdr_reg;
   logic [DATA_W-1:0] hold_reg;

   // Header and its address field are captured together when the FSM sees a new packet.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hdr_reg   <= '0;
         dest_addr <= '0;
      end else if (detect_add && pkt_valid) begin
         hdr_reg   <= data_in;
         dest_addr <= ADDR_W'(hdr_addr(HDR_MAX_W'(data_in), ADDR_W));
      end
   end

   // Output steering; a byte arriving while the FIFO is full is parked for replay in load-after-full.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dout     <= '0;
         hold_reg <= '0;
      end else if (lfd_state) begin
         dout <= hdr_reg;
      end else if (ld_state && !fifo_full) begin
         dout <= data_in;
      end else if (ld_state && fifo_full) begin
         hold_reg <= data_in;
      end else if (laf_state) begin
         dout <= hold_reg;
      end
   end

   // Sticky flag for pkt_valid dropping during load; clear wins over a same-cycle set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         low_pkt_valid <= 1'b0;
      end else if (rst_int_reg) begin
         low_pkt_valid <= 1'b0;
      end else if (ld_state && !pkt_valid) begin
         low_pkt_valid <= 1'b1;
      end
   end

   router_parity_acc #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_parity_acc (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .fifo_full     (fifo_full),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .data_in       (data_in),
      .hdr_reg       (hdr_reg),
      .parity_done   (parity_done),
      .err           (err),
      .len_err       (len_err)
   );

endmodule

// File: tb/tb_router_reg_p.sv
// tb_router_reg_p: bench for router_reg_p with the FSM decodes driven directly. Expected dout
// bytes are queued as stimulus is driven and compared after the edge that should load them.
module tb_router_reg_p;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       fifo_full;
   logic       rst_int_reg;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       err;
   logic       len_err;
   logic [1:0] dest_addr;
   logic [7:0] dout;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] sb_q [$];
   logic [7:0] last_dout;

`ifdef ROUTER_REG_LEN_CHECK_EN
   localparam bit LEN_CHK = 1'b1;
`else
   localparam bit LEN_CHK = 1'b0;
`endif

   router_reg_p #(.DATA_W(8), .ADDR_W(2)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .rst_int_reg   (rst_int_reg),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .err           (err),
      .len_err       (len_err),
      .dest_addr     (dest_addr),
      .dout          (dout)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      detect_add  = 1'b0;
      lfd_state   = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      fifo_full   = 1'b0;
      rst_int_reg = 1'b0;
   endtask

   // One clock; if a dout load was queued, compare against the scoreboard, else dout must hold.
   task automatic tick(input bit load);
      @(posedge clock);
      #1;
      if (load) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            last_dout = sb_q.pop_front();
            chk("dout", dout, last_dout);
         end
      end else begin
         chk("dout_hold", dout, last_dout);
      end
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input int n, input bit corrupt,
                           input int stall_idx, input bit sim_clr);
      logic [7:0] pl [$];
      logic [7:0] par;
      logic [7:0] b;
      bit         exp_len;
      par = hdr;
      for (int i = 0; i < n; i++) begin
         b = (i == stall_idx) ? 8'h5C : 8'($urandom_range(0, 255));
         pl.push_back(b);
         par = par ^ b;
      end
      if (corrupt) par = par ^ 8'h01;
      exp_len = LEN_CHK && (n != int'(hdr[7:2]));

      idle();
      detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
      tick(1'b0);
      chk("dest_addr", 32'(dest_addr), 32'(hdr[1:0]));
      chk("err_cleared", 32'(err), 32'd0);
      chk("pdone_cleared", 32'(parity_done), 32'd0);
      chk("len_err_cleared", 32'(len_err), 32'd0);

      detect_add = 1'b0; lfd_state = 1'b1; data_in = pl[0];
      sb_q.push_back(hdr);
      tick(1'b1);
      lfd_state = 1'b0;

      for (int i = 0; i < n; i++) begin
         ld_state = 1'b1; pkt_valid = 1'b1; data_in = pl[i];
         if (i == stall_idx) begin
            fifo_full = 1'b1;
            tick(1'b0);
            ld_state = 1'b0; full_state = 1'b1;
            tick(1'b0);
            full_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
            sb_q.push_back(pl[i]);
            tick(1'b1);
            chk("laf_replay", 32'(dout), 32'h5C);
            laf_state = 1'b0;
         end else begin
            fifo_full = 1'b0;
            sb_q.push_back(pl[i]);
            tick(1'b1);
         end
      end

      ld_state = 1'b1; pkt_valid = 1'b0; data_in = par; rst_int_reg = sim_clr;
      sb_q.push_back(par);
      tick(1'b1);
      idle();
      chk("parity_done", 32'(parity_done), 32'd1);
      chk("low_pkt_valid_set", 32'(low_pkt_valid), sim_clr ? 32'd0 : 32'd1);
      chk("err_not_yet", 32'(err), 32'd0);

      tick(1'b0);
      chk("err", 32'(err), 32'(corrupt));
      chk("len_err", 32'(len_err), 32'(exp_len));

      if (!sim_clr) begin
         rst_int_reg = 1'b1;
         tick(1'b0);
         rst_int_reg = 1'b0;
         chk("low_pkt_valid_clr", 32'(low_pkt_valid), 32'd0);
      end
   endtask

   initial begin
      last_dout = 8'h00;
      idle();
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      resetn    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_dest_addr", 32'(dest_addr), 32'd0);
      chk("rst_parity_done", 32'(parity_done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      resetn = 1'b1;
      tick(1'b0);

      send_pkt(8'h3A, 14, 1'b0, -1, 1'b0);   // good packet
      send_pkt(8'h3A, 14, 1'b1, -1, 1'b0);   // corrupt parity
      send_pkt(8'h3A, 13, 1'b0, -1, 1'b0);   // length mismatch (detect_add clears prior err)
      send_pkt(8'h3A, 14, 1'b0,  5, 1'b0);   // FIFO full stall on byte 0x5C
      send_pkt(8'h17,  5, 1'b0, -1, 1'b1);   // addr 3, len 5, simultaneous set/clear

      // Partial packet, then reset mid-packet with several outputs non-zero.
      idle();
      detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h3A;
      tick(1'b0);
      detect_add = 1'b0; lfd_state = 1'b1;
      sb_q.push_back(8'h3A);
      tick(1'b1);
      lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'hA5;
      sb_q.push_back(8'hA5);
      tick(1'b1);
      pkt_valid = 1'b0; data_in = 8'hC3;
      sb_q.push_back(8'hC3);
      tick(1'b1);
      idle();
      chk("pre_rst_low_pkt_valid", 32'(low_pkt_valid), 32'd1);
      chk("pre_rst_dest_addr", 32'(dest_addr), 32'd2);
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_dout", 32'(dout), 32'd0);
      chk("mid_rst_dest_addr", 32'(dest_addr), 32'd0);
      chk("mid_rst_parity_done", 32'(parity_done), 32'd0);
      chk("mid_rst_low_pkt_valid", 32'(low_pkt_valid), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_len_err", 32'(len_err), 32'd0);
      last_dout = 8'h00;
      @(negedge clock);
      resetn = 1'b1;
      tick(1'b0);

      send_pkt(8'h3A, 14, 1'b0, -1, 1'b0);   // clean packet after reset

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
